// File: rtl/gpio_port_ctrl_if.sv
// Wishbone slave bus bundle for the GPIO port controller.
// Signal names follow the controller's point of view (_i into it, _o out).
interface gpio_port_ctrl_if;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i,
        output wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i,
        input  wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gpio_port_ctrl.sv
// Wishbone GPIO port controller: DAT/TRIS latches, synchronized pin readback.
// Define GPIO_INTR_EN to add IEN/ISTAT rising-edge interrupt logic.
module gpio_port_ctrl #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    gpio_port_ctrl_if.slave  wb,
    output logic [N-1:0]     gpio_dir_o,
    output logic [N-1:0]     gpio_bit_o,
    input  logic [N-1:0]     gpio_bit_i,
    output logic             irq_o
);

    logic           r_ack;
    logic [31:0]    r_dat_o;
    logic [N-1:0]   r_tris;
    logic [N-1:0]   r_dat;
    logic [N-1:0]   r_sync [SYNC_STAGES];

    logic           w_req;
    logic           w_wr;
    logic           w_rd;
    logic [31:0]    w_mask;
    logic [N-1:0]   w_wmask;
    logic [N-1:0]   w_wdat;
    logic [N-1:0]   w_sync;
    logic [31:0]    w_rdata;
    logic           w_unused;

    // Ack gates the next request so a held strobe acks every other cycle.
    assign w_req   = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr    = w_req & wb.wb_we_i;
    assign w_rd    = w_req & ~wb.wb_we_i;
    assign w_mask  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                      {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign w_wmask = w_mask[N-1:0];
    assign w_wdat  = wb.wb_dat_i[N-1:0];
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_unused = &{1'b0, wb.wb_dat_i, w_mask};

    function automatic logic [N-1:0] merge(
        input logic [N-1:0] old_v,
        input logic [N-1:0] new_v,
        input logic [N-1:0] m
    );
        return (old_v & ~m) | (new_v & m);
    endfunction

`ifdef GPIO_INTR_EN
    logic [N-1:0]   r_ien;
    logic [N-1:0]   r_istat;
    logic [N-1:0]   r_prev;
    logic           r_irq;
    logic [N-1:0]   w_rise;
    logic [N-1:0]   w_w1c;

    assign w_rise = w_sync & ~r_prev & r_ien;
    assign w_w1c  = (w_wr && wb.wb_adr_i == 2'd3) ? (w_wdat & w_wmask) : '0;

    // A new edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ien   <= '0;
            r_istat <= '0;
            r_prev  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_prev  <= w_sync;
            r_istat <= (r_istat & ~w_w1c) | w_rise;
            r_irq   <= |r_istat;
            if (w_wr && wb.wb_adr_i == 2'd2)
                r_ien <= merge(r_ien, w_wdat, w_wmask);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (wb.wb_adr_i)
            2'd0: w_rdata[N-1:0] = w_sync;
            2'd1: w_rdata[N-1:0] = r_tris;
`ifdef GPIO_INTR_EN
            2'd2: w_rdata[N-1:0] = r_ien;
            2'd3: w_rdata[N-1:0] = r_istat;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_tris  <= '1;
            r_dat   <= '0;
            for (int k = 0; k < SYNC_STAGES; k++)
                r_sync[k] <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_rd ? w_rdata : '0;
            r_sync[0] <= gpio_bit_i;
            for (int k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
            if (w_wr && wb.wb_adr_i == 2'd0)
                r_dat <= merge(r_dat, w_wdat, w_wmask);
            if (w_wr && wb.wb_adr_i == 2'd1)
                r_tris <= merge(r_tris, w_wdat, w_wmask);
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
    assign gpio_dir_o  = r_tris;
    assign gpio_bit_o  = r_dat;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl (N=16, SYNC_STAGES=2).
// Interrupt checks compile in when GPIO_INTR_EN is defined.
module tb_gpio_port_ctrl;

    localparam int N  = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  dir_o;
    logic [N-1:0]  bit_o;
    logic [N-1:0]  bit_i;
    logic          irq;

    int total = 0;
    int bad   = 0;

    gpio_port_ctrl_if bus ();

    gpio_port_ctrl #(.N(N), .SYNC_STAGES(SS)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb         (bus),
        .gpio_dir_o (dir_o),
        .gpio_bit_o (bit_o),
        .gpio_bit_i (bit_i),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        bus.wb_adr_i = 2'd0;
        bus.wb_dat_i = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access: request for one cycle, ack must be high right after.
    task automatic acc(input logic we, input logic [1:0] adr,
                       input logic [31:0] d, input logic [3:0] sel,
                       output logic [31:0] rd);
        step(1);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        step(1);
        chk("ack_latency", {31'd0, bus.wb_ack_o}, 32'd1);
        rd = bus.wb_dat_o;
        idle();
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] d,
                      input logic [3:0] sel);
        logic [31:0] dummy;
        acc(1'b1, adr, d, sel, dummy);
    endtask

    task automatic rd(input logic [1:0] adr, output logic [31:0] q);
        acc(1'b0, adr, 32'h0, 4'h0, q);
    endtask

    initial begin
        logic [31:0] q;
        logic [5:0]  pat;
        int          acks;
        bit          seen;

        idle();
        bit_i = '0;
        rst_n = 1'b0;
        step(3);
        chk("rst_dir", {16'd0, dir_o}, 32'h0000_FFFF);
        chk("rst_bit", {16'd0, bit_o}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'h0);
        rst_n = 1'b1;

        rd(2'd1, q);
        chk("rd_tris_rst", q, 32'h0000_FFFF);
        rd(2'd0, q);
        chk("rd_dat_pins0", q, 32'h0);

        wr(2'd1, 32'h0000_0000, 4'hF);
        chk("dir_in_ack", {16'd0, dir_o}, 32'h0);
        wr(2'd0, 32'h0000_A5A5, 4'hF);
        chk("bit_in_ack", {16'd0, bit_o}, 32'h0000_A5A5);
        rd(2'd0, q);
        chk("dat_reads_pins", q, 32'h0);
        rd(2'd1, q);
        chk("rd_tris0", q, 32'h0);

        wr(2'd0, 32'h0, 4'hF);
        wr(2'd0, 32'hFFFF_FFFF, 4'b0001);
        chk("sel_lane0", {16'd0, bit_o}, 32'h0000_00FF);
        wr(2'd1, 32'hFFFF_FFFF, 4'b0010);
        chk("sel_lane1_tris", {16'd0, dir_o}, 32'h0000_FF00);
        rd(2'd1, q);
        chk("tris_hi_zero", q, 32'h0000_FF00);

        // Pin change at cycle t; read at t+1 is stale, later reads see it.
        bit_i = 16'h1234;
        rd(2'd0, q);
        chk("sync_old", q, 32'h0);
        rd(2'd0, q);
        chk("sync_new", q, 32'h0000_1234);

`ifdef GPIO_INTR_EN
        wr(2'd2, 32'h0000_0001, 4'hF);
        rd(2'd2, q);
        chk("ien_rd", q, 32'h1);
        bit_i = 16'h1235;
        seen = 1'b0;
        for (int i = 0; i < SS + 2; i++) begin
            step(1);
            if (irq) seen = 1'b1;
        end
        chk("irq_rise", {31'd0, seen}, 32'h1);
        rd(2'd3, q);
        chk("istat_set", q, 32'h1);
        wr(2'd3, 32'h0000_0001, 4'hF);
        step(1);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        rd(2'd3, q);
        chk("istat_clr", q, 32'h0);
        bit_i = 16'h1234;
        step(4);
        bit_i = 16'h1235;
        step(1);
        wr(2'd3, 32'h0000_0001, 4'hF);
        rd(2'd3, q);
        chk("set_beats_w1c", q, 32'h1);
        wr(2'd2, 32'h0, 4'hF);
        rd(2'd3, q);
        chk("ien_off_keeps", q, 32'h1);
        step(1);
        chk("irq_pending", {31'd0, irq}, 32'h1);
`else
        wr(2'd2, 32'hFFFF_FFFF, 4'hF);
        rd(2'd2, q);
        chk("ien_absent", q, 32'h0);
        bit_i = 16'h1235;
        step(6);
        rd(2'd3, q);
        chk("istat_absent", q, 32'h0);
        chk("irq_tied", {31'd0, irq}, 32'h0);
`endif

        // Held strobe acks every other cycle.
        step(1);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 2'd1;
        acks = 0;
        pat  = '0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            pat[5-i] = bus.wb_ack_o;
            if (bus.wb_ack_o) acks++;
        end
        chk("held_acks", acks, 32'd3);
        chk("held_pattern", {26'd0, pat}, 32'b101010);
        idle();
        step(2);

        wr(2'd0, 32'h0000_5A5A, 4'hF);
        step(1);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 2'd1;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'hF;
        rst_n = 1'b0;
        step(1);
        chk("rst_drops_ack", {31'd0, bus.wb_ack_o}, 32'h0);
        chk("rst_dir2", {16'd0, dir_o}, 32'h0000_FFFF);
        chk("rst_bit2", {16'd0, bit_o}, 32'h0);
        chk("rst_dato", bus.wb_dat_o, 32'h0);
        idle();
        step(1);
        chk("rst_irq2", {31'd0, irq}, 32'h0);
        rst_n = 1'b1;
        bit_i = '0;
        rd(2'd1, q);
        chk("tris_after_rst", q, 32'h0000_FFFF);
        rd(2'd2, q);
        chk("ien_after_rst", q, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
